elastic_alu_pipe: RTL and testbench

- Parametrised successor of the elastic ALU in each PE.
- Executes one configured op per token under SELF valid/stop handshake.
- Per-op latency is set by parameters; load/store use a fixed-latency memory port.
- An output FIFO decouples result delivery from stop_output, so a new token can be accepted while earlier results are stalled.

---
 rtl/elastic_alu_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_elastic_alu_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_alu_pipe.sv
// elastic_alu_pipe: one-op-per-token elastic ALU with parametrised per-op
// latency, a fixed-latency memory port for load/store and an output FIFO
// that decouples result delivery from consumer backpressure.
//
// Handshake: a token is transferred on the producer side in a cycle where
// (valid_input | op is const) & !stop_input, and on the consumer side in a
// cycle where valid_output & !stop_output; both sides sample on rising clk.
module elastic_alu_pipe #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16,
    parameter int OP_WIDTH      = 5,
    parameter int ADD_CYCLE     = 1,
    parameter int MUL_CYCLE     = 3,
    parameter int DIV_CYCLE     = 8,
    parameter int MEM_LATENCY   = 2,
    parameter int OUT_DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_WIDTH-1:0]    input_data_1,
    input  logic [DATA_WIDTH-1:0]    input_data_2,
    input  logic [OP_WIDTH-1:0]      op,
    input  logic [DATA_WIDTH-1:0]    const_data,
    input  logic                     valid_input,
    output logic                     stop_input,
    output logic [DATA_WIDTH-1:0]    output_data,
    output logic                     valid_output,
    input  logic                     stop_output,
    output logic [ADDRESS_WIDTH-1:0] memory_read_address,
    input  logic [DATA_WIDTH-1:0]    memory_read_data,
    output logic                     memory_write,
    output logic [ADDRESS_WIDTH-1:0] memory_write_address,
    output logic [DATA_WIDTH-1:0]    memory_write_data,
    output logic                     switch_context,
    output logic                     div_by_zero,
    output logic [1:0]               state_dbg_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_NOP   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_CONST = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_LOAD  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_OUT   = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_ROUTE = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_STORE = OP_WIDTH'(9);

    localparam int MAX_AM  = (ADD_CYCLE > MUL_CYCLE) ? ADD_CYCLE : MUL_CYCLE;
    localparam int MAX_DM  = (DIV_CYCLE > MEM_LATENCY) ? DIV_CYCLE : MEM_LATENCY;
    localparam int MAX_LAT = (MAX_AM > MAX_DM) ? MAX_AM : MAX_DM;
    // Counter holds latency-1, so $clog2(MAX_LAT) bits are enough.
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCC_W   = $clog2(OUT_DEPTH + 1);

    // FSM and latched token
    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [OP_WIDTH-1:0]       op_q;
    logic [DATA_WIDTH-1:0]     a_q;
    logic [DATA_WIDTH-1:0]     b_q;
    logic [DATA_WIDTH-1:0]     k_q;
    logic                      rst_done_q;
    logic                      mem_wr_q;
    logic [ADDRESS_WIDTH-1:0]  mem_wa_q;
    logic [DATA_WIDTH-1:0]     mem_wd_q;
    logic [ADDRESS_WIDTH-1:0]  mem_ra_q;
    logic                      dbz_q;

    // Output FIFO
    logic [DATA_WIDTH-1:0]     fifo_q [OUT_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [OCC_W-1:0]          count_q;

    // Handshake / datapath nets
    logic                      op_known;
    logic                      is_const;
    logic                      inflight;
    logic [OCC_W:0]            occupancy;
    logic                      full_or_reserved;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic [DATA_WIDTH-1:0]     result;

    function automatic logic [CNT_W-1:0] lat_m1(input logic [OP_WIDTH-1:0] o);
        case (o)
            OP_MUL:  return CNT_W'(MUL_CYCLE - 1);
            OP_DIV:  return CNT_W'(DIV_CYCLE - 1);
            OP_LOAD: return CNT_W'(MEM_LATENCY - 1);
            default: return CNT_W'(ADD_CYCLE - 1);
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Only ops 1..9 are executable; nop and undefined codes hold the producer.
    assign op_known  = (op != OP_NOP) && (op <= OP_STORE);
    assign is_const  = (op == OP_CONST);
    assign inflight  = (state_q != ST_IDLE);

    // A slot is reserved at accept, so queued plus in-flight results bound acceptance.
    assign occupancy        = (OCC_W+1)'(count_q) + (OCC_W+1)'(inflight);
    assign full_or_reserved = (occupancy == (OCC_W+1)'(OUT_DEPTH));

    // Held high during reset and until the first clock edge after release.
    assign stop_input = !rst_done_q || inflight || full_or_reserved || !op_known;
    assign accept     = !stop_input && (is_const || valid_input);

    assign push = inflight && (cnt_q == '0);
    assign pop  = valid_output && !stop_output;

    // Result of the latched op, consumed only on the push cycle.
    always_comb begin
        result = '0;
        case (op_q)
            OP_ADD:   result = a_q + b_q;
            OP_SUB:   result = a_q - b_q;
            OP_MUL:   result = a_q * b_q;
            OP_DIV:   result = (b_q == '0) ? '1 : (a_q / b_q);
            OP_CONST: result = k_q;
            OP_LOAD:  result = memory_read_data;
            OP_OUT:   result = a_q;
            OP_ROUTE: result = a_q;
            OP_STORE: result = b_q;
            default:  result = '0;
        endcase
    end

    // Token FSM: accept, count down the op latency, push, and drive the memory port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            rst_done_q <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_wa_q   <= '0;
            mem_wd_q   <= '0;
            mem_ra_q   <= '0;
            dbz_q      <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            mem_wr_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        a_q   <= input_data_1;
                        b_q   <= input_data_2;
                        k_q   <= const_data;
                        cnt_q <= lat_m1(op);
                        if (op == OP_LOAD) begin
                            state_q  <= ST_MEM;
                            mem_ra_q <= input_data_1[ADDRESS_WIDTH-1:0];
                        end else begin
                            state_q <= ST_EXEC;
                        end
                        if (op == OP_STORE) begin
                            mem_wr_q <= 1'b1;
                            mem_wa_q <= input_data_1[ADDRESS_WIDTH-1:0];
                            mem_wd_q <= input_data_2;
                        end
                    end
                end
                ST_EXEC, ST_MEM: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        if ((op_q == OP_DIV) && (b_q == '0)) begin
                            dbz_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output FIFO: simultaneous push and pop keeps the count and preserves order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= result;
                wr_ptr_q         <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign output_data          = fifo_q[rd_ptr_q];
    assign valid_output         = (count_q != '0);
    assign switch_context       = pop;
    assign memory_read_address  = mem_ra_q;
    assign memory_write         = mem_wr_q;
    assign memory_write_address = mem_wa_q;
    assign memory_write_data    = mem_wd_q;
    assign div_by_zero          = dbz_q;
    assign state_dbg_o          = state_q;

endmodule

// File: tb/tb_elastic_alu_pipe.sv
// Directed testbench for elastic_alu_pipe with an output scoreboard.
module tb_elastic_alu_pipe;

  logic        clk;
  logic        reset_n;
  logic [31:0] input_data_1;
  logic [31:0] input_data_2;
  logic [4:0]  op;
  logic [31:0] const_data;
  logic        valid_input;
  logic        stop_input;
  logic [31:0] output_data;
  logic        valid_output;
  logic        stop_output;
  logic [15:0] memory_read_address;
  logic [31:0] memory_read_data;
  logic        memory_write;
  logic [15:0] memory_write_address;
  logic [31:0] memory_write_data;
  logic        switch_context;
  logic        div_by_zero;
  logic [1:0]  state_dbg;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_pop  = 0;
  int n_wr   = 0;
  bit const_mode = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [256];
  logic [31:0] rd_q;

  elastic_alu_pipe dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .input_data_1         (input_data_1),
    .input_data_2         (input_data_2),
    .op                   (op),
    .const_data           (const_data),
    .valid_input          (valid_input),
    .stop_input           (stop_input),
    .output_data          (output_data),
    .valid_output         (valid_output),
    .stop_output          (stop_output),
    .memory_read_address  (memory_read_address),
    .memory_read_data     (memory_read_data),
    .memory_write         (memory_write),
    .memory_write_address (memory_write_address),
    .memory_write_data    (memory_write_data),
    .switch_context       (switch_context),
    .div_by_zero          (div_by_zero),
    .state_dbg_o          (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: one registered read stage, data stable by MEM_LATENCY edges
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rd_q = '0;
  end
  always @(posedge clk) begin
    rd_q <= mem[memory_read_address[7:0]];
    if (memory_write) begin
      n_wr++;
      mem[memory_write_address[7:0]] <= memory_write_data;
    end
  end
  assign memory_read_data = rd_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every consumer-side transfer is compared in order
  always @(negedge clk) begin
    if (reset_n && valid_output && !stop_output) begin
      n_pop++;
      check("switch_context", {31'd0, switch_context}, 32'd1);
      if (const_mode) check("const_out", output_data, 32'd42);
      else if (exp_q.size() == 0) check("sb_empty", 32'(exp_q.size()), 32'd1);
      else check("sb_out", output_data, exp_q.pop_front());
    end
  end

  // driver: present a token, wait (bounded) for its accept edge, end 1ns after it
  task automatic send(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    bit done = 0;
    op = o;
    input_data_1 = a;
    input_data_2 = b;
    valid_input = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!stop_input) begin
        @(posedge clk);
        #1;
        valid_input = 1'b0;
        done = 1;
      end
    end
    if (!done) check("send_timeout", {31'd0, stop_input}, 32'd0);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !valid_output && state_dbg == 2'd0) done = 1;
    end
    check("drain", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int base;
    reset_n = 1'b0;
    input_data_1 = '0;
    input_data_2 = '0;
    op = 5'd0;
    const_data = '0;
    valid_input = 1'b0;
    stop_output = 1'b0;
    #2;
    check("rst_stop_input", {31'd0, stop_input}, 32'd1);
    check("rst_valid_output", {31'd0, valid_output}, 32'd0);
    check("rst_mem_write", {31'd0, memory_write}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_output_data", output_data, 32'd0);

    // release with an executable op: stop_input must still be high until first edge
    op = 5'd1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("stop_before_first_edge", {31'd0, stop_input}, 32'd1);
    @(posedge clk);
    #1;
    check("stop_after_first_edge", {31'd0, stop_input}, 32'd0);

    // add 5+7, single-cycle latency
    exp_q.push_back(32'd12);
    send(5'd1, 32'd5, 32'd7);
    check("add_busy", {31'd0, stop_input}, 32'd1);
    check("add_not_yet_valid", {31'd0, valid_output}, 32'd0);
    @(posedge clk);
    #1;
    check("add_valid", {31'd0, valid_output}, 32'd1);
    check("add_data", output_data, 32'd12);
    check("add_switch", {31'd0, switch_context}, 32'd1);
    @(posedge clk);
    #1;
    check("add_popped", {31'd0, valid_output}, 32'd0);

    // mul with 3-cycle latency, truncated product
    exp_q.push_back(32'hFFFF_FFFE);
    send(5'd3, 32'hFFFF_FFFF, 32'd2);
    check("mul_stop_c1", {31'd0, stop_input}, 32'd1);
    @(posedge clk);
    #1;
    check("mul_stop_c2", {31'd0, stop_input}, 32'd1);
    check("mul_novalid_c2", {31'd0, valid_output}, 32'd0);
    @(posedge clk);
    #1;
    check("mul_stop_c3", {31'd0, stop_input}, 32'd1);
    check("mul_novalid_c3", {31'd0, valid_output}, 32'd0);
    @(posedge clk);
    #1;
    check("mul_valid", {31'd0, valid_output}, 32'd1);
    check("mul_data", output_data, 32'hFFFF_FFFE);
    check("mul_stop_released", {31'd0, stop_input}, 32'd0);
    wait_drain();

    // backpressure: only OUT_DEPTH tokens accepted while consumer stalls
    stop_output = 1'b1;
    base = n_pop;
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd8);
    send(5'd1, 32'd1, 32'd1);
    send(5'd1, 32'd2, 32'd2);
    op = 5'd1;
    input_data_1 = 32'd3;
    input_data_2 = 32'd3;
    valid_input = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_stop_held", {31'd0, stop_input}, 32'd1);
    end
    check("bp_head_valid", {31'd0, valid_output}, 32'd1);
    check("bp_head_data", output_data, 32'd2);
    check("bp_no_pops", 32'(n_pop - base), 32'd0);
    @(posedge clk);
    #1;
    stop_output = 1'b0;
    send(5'd1, 32'd3, 32'd3);
    send(5'd1, 32'd4, 32'd4);
    wait_drain();
    check("bp_pop_count", 32'(n_pop - base), 32'd4);

    // divide by zero, then a normal divide keeps the sticky flag
    exp_q.push_back(32'hFFFF_FFFF);
    send(5'd4, 32'd9, 32'd0);
    check("dbz_not_yet", {31'd0, div_by_zero}, 32'd0);
    wait_drain();
    check("dbz_set", {31'd0, div_by_zero}, 32'd1);
    exp_q.push_back(32'd3);
    send(5'd4, 32'd9, 32'd3);
    wait_drain();
    check("dbz_sticky", {31'd0, div_by_zero}, 32'd1);

    // store 0xAB to 0x10, then load it back
    base = n_wr;
    exp_q.push_back(32'hAB);
    send(5'd9, 32'h10, 32'hAB);
    check("st_write", {31'd0, memory_write}, 32'd1);
    check("st_addr", {16'd0, memory_write_address}, 32'h10);
    check("st_data", memory_write_data, 32'hAB);
    @(posedge clk);
    #1;
    check("st_write_pulse", {31'd0, memory_write}, 32'd0);
    wait_drain();
    check("st_write_count", 32'(n_wr - base), 32'd1);
    exp_q.push_back(32'hAB);
    send(5'd6, 32'h10, 32'd0);
    check("ld_addr", {16'd0, memory_read_address}, 32'h10);
    @(posedge clk);
    #1;
    check("ld_not_yet", {31'd0, valid_output}, 32'd0);
    @(posedge clk);
    #1;
    check("ld_valid", {31'd0, valid_output}, 32'd1);
    check("ld_data", output_data, 32'hAB);
    wait_drain();
    check("ld_no_write", 32'(n_wr - base), 32'd1);

    // reset during a div with a result queued in the FIFO
    stop_output = 1'b1;
    send(5'd1, 32'd1, 32'd2);
    send(5'd4, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    check("pre_reset_valid", {31'd0, valid_output}, 32'd1);
    check("pre_reset_busy", {30'd0, state_dbg}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_valid", {31'd0, valid_output}, 32'd0);
    check("mid_reset_stop", {31'd0, stop_input}, 32'd1);
    check("mid_reset_state", {30'd0, state_dbg}, 32'd0);
    check("mid_reset_dbz", {31'd0, div_by_zero}, 32'd0);

    // const stream: no valid_input needed
    stop_output = 1'b0;
    op = 5'd5;
    const_data = 32'd42;
    valid_input = 1'b0;
    const_mode = 1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    base = n_pop;
    repeat (40) @(posedge clk);
    #1;
    op = 5'd0;
    wait_drain();
    check("const_rate", {31'd0, (n_pop - base) >= 10}, 32'd1);
    check("nop_stall", {31'd0, stop_input}, 32'd1);
    check("nop_idle", {31'd0, valid_output}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
